// File: rtl/avg_window_ctrl.sv
// avg_window_ctrl: sequencer for the sample-averaging datapath.
// Collects a window of 2**LOG2N samples over a valid/ready handshake,
// divides the accumulated sum into an average, then flags each later
// sample that is strictly above that average.
//
// Build option: define AVG_ROUND_EN to round the average half-up;
// leave it undefined to truncate.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   begin a new window (ignored while accumulating)
//   abort    in   return to idle from any state; wins over start/accept
//   x_valid  in   sample valid
//   x        in   W-bit unsigned sample
//   x_ready  out  sample accepted when x_valid && x_ready
//   busy     out  high while accumulating or dividing
//   done     out  one-cycle pulse on entry to compare mode
//   avg      out  last computed window average (held)
//   y        out  last accepted compare-mode sample > avg
module avg_window_ctrl #(
  parameter int unsigned W     = 4,
  parameter int unsigned LOG2N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         x_valid,
  input  logic [W-1:0] x,
  output logic         x_ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] avg,
  output logic         y
);

  localparam int unsigned AW = W + LOG2N;
  localparam int unsigned N  = 1 << LOG2N;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DIVIDE = 2'd2,
    S_CMP    = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [AW-1:0]    acc;
  logic [LOG2N-1:0] cnt;
  logic [W-1:0]     avg_d;
  logic             x_ready_d, busy_d, done_d;
  logic             accept;
  logic             last_sample;

  assign accept      = x_valid && x_ready;
  assign last_sample = (cnt == LOG2N'(N - 1));

  // State register and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      x_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      x_ready <= x_ready_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_next = S_ACCUM;
        S_ACCUM:  if (accept && last_sample) state_next = S_DIVIDE;
        S_DIVIDE: state_next = S_CMP;
        S_CMP:    if (start) state_next = S_ACCUM;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the outputs can be registered
  always_comb begin
    x_ready_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_next)
      S_ACCUM:  begin x_ready_d = 1'b1; busy_d = 1'b1; end
      S_DIVIDE: busy_d = 1'b1;
      S_CMP:    x_ready_d = 1'b1;
      default:  ;
    endcase
    done_d = (state == S_DIVIDE) && (state_next == S_CMP);
  end

  // Average of the window; the accumulator has headroom for the rounding bias
`ifdef AVG_ROUND_EN
  localparam logic [AW-1:0] HALF = AW'(N / 2);
  logic [AW-1:0] acc_rnd;
  always_comb begin
    acc_rnd = acc + HALF;
    avg_d   = W'(acc_rnd >> LOG2N);
  end
`else
  always_comb begin
    avg_d = W'(acc >> LOG2N);
  end
`endif

  // Accumulator, sample count, average and compare result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      avg <= '0;
      y   <= 1'b0;
    end else if (abort) begin
      acc <= '0;
      cnt <= '0;
      y   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc <= acc + AW'(x);
            cnt <= cnt + LOG2N'(1);
          end
        end
        S_DIVIDE: avg <= avg_d;
        S_CMP: begin
          if (start) begin
            acc <= '0;
            cnt <= '0;
            y   <= 1'b0;
          end else if (accept) begin
            y <= (x > avg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
